// File: rtl/mae_pkg.sv
// Shared widths and helpers for the MAE hard DSP slice model.
package mae_pkg;

   localparam int unsigned A_W = 18;
   localparam int unsigned B_W = 18;
   localparam int unsigned C_W = 40;
   localparam int unsigned P_W = 40;
   localparam int unsigned M_W = 36;

   // Widen the raw 36-bit signed product onto the 40-bit adder/result lane.
   function automatic logic signed [P_W-1:0] mae_sext36to40(input logic signed [M_W-1:0] m);
      return {{(P_W-M_W){m[M_W-1]}}, m};
   endfunction

endpackage

// File: rtl/mae_dsp_core_if.sv
// Operand, register-control and result bundle of the MAE DSP slice.
interface mae_dsp_core_if;
   import mae_pkg::*;

   logic signed [A_W-1:0] A;
   logic                  A_EN;
   logic                  A_SRST_N;
   logic signed [B_W-1:0] B;
   logic                  B_EN;
   logic                  B_SRST_N;
   logic signed [C_W-1:0] C;
   logic                  C_EN;
   logic                  C_SRST_N;
   logic                  CDIN_FDBK_SEL;
   logic                  P_EN;
   logic                  P_SRST_N;
   logic signed [P_W-1:0] P;

   modport master (
      output A, A_EN, A_SRST_N, B, B_EN, B_SRST_N, C, C_EN, C_SRST_N,
             CDIN_FDBK_SEL, P_EN, P_SRST_N,
      input  P
   );

   modport slave (
      input  A, A_EN, A_SRST_N, B, B_EN, B_SRST_N, C, C_EN, C_SRST_N,
             CDIN_FDBK_SEL, P_EN, P_SRST_N,
      output P
   );

endinterface

// File: rtl/mae_pipe_reg.sv
// Optional pipeline stage: async clear, sync active-low clear, clock enable,
// or a plain wire when the stage is configured out.
module mae_pipe_reg #(
   parameter int unsigned WIDTH      = 18,
   parameter bit          REGISTERED = 1'b1
) (
   input  logic             CLK,
   input  logic             ARST,
   input  logic             EN,
   input  logic             SRST_N,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] q_r;

      // Sync clear outranks the enable.
      always_ff @(posedge CLK or posedge ARST) begin
         if (ARST)         q_r <= '0;
         else if (!SRST_N) q_r <= '0;
         else if (EN)      q_r <= D;
      end

      assign Q = q_r;
   end else begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, ARST, EN, SRST_N};
      assign Q = D;
   end

endmodule

// File: rtl/mae_dsp_core.sv
// Behavioural Z1010 MAE DSP slice: signed 18x18 multiply with optional
// A/B/C/multiplier/P registers and a 40-bit post-adder fed from C or P.
module mae_dsp_core
   import mae_pkg::*;
#(
   parameter bit BYPASS_A          = 1'b0,
   parameter bit BYPASS_B          = 1'b0,
   parameter bit BYPASS_C          = 1'b0,
   parameter bit BYPASS_P          = 1'b0,
   parameter bit MULT_HAS_REG      = 1'b0,
   parameter bit POST_ADDER_STATIC = 1'b0,
   parameter bit USE_FEEDBACK      = 1'b0
) (
   input  logic           CLK,
   input  logic           ARST,
   mae_dsp_core_if.slave  bus
);

   if (BYPASS_A != BYPASS_B) begin : g_err_ab
      $error("mae_dsp_core: BYPASS_A and BYPASS_B must be equal");
   end

   if (USE_FEEDBACK && (!BYPASS_P || !POST_ADDER_STATIC)) begin : g_err_fb
      $error("mae_dsp_core: USE_FEEDBACK needs BYPASS_P=1 and POST_ADDER_STATIC=1");
   end

   logic signed [A_W-1:0] a_q;
   logic signed [B_W-1:0] b_q;
   logic signed [C_W-1:0] c_q;
   logic signed [M_W-1:0] m_full;
   logic signed [P_W-1:0] m;
   logic signed [P_W-1:0] m_q;
   logic signed [P_W-1:0] x;
   logic signed [P_W-1:0] s;
   logic signed [P_W-1:0] p_q;

   mae_pipe_reg #(.WIDTH(A_W), .REGISTERED(BYPASS_A)) u_a_reg (
      .CLK(CLK), .ARST(ARST), .EN(bus.A_EN), .SRST_N(bus.A_SRST_N),
      .D(bus.A), .Q(a_q)
   );

   mae_pipe_reg #(.WIDTH(B_W), .REGISTERED(BYPASS_B)) u_b_reg (
      .CLK(CLK), .ARST(ARST), .EN(bus.B_EN), .SRST_N(bus.B_SRST_N),
      .D(bus.B), .Q(b_q)
   );

   mae_pipe_reg #(.WIDTH(C_W), .REGISTERED(BYPASS_C)) u_c_reg (
      .CLK(CLK), .ARST(ARST), .EN(bus.C_EN), .SRST_N(bus.C_SRST_N),
      .D(bus.C), .Q(c_q)
   );

   // Operands are widened before multiplying so the low 36 bits hold the full signed product.
   assign m_full = M_W'(a_q) * M_W'(b_q);
   assign m      = mae_sext36to40(m_full);

   mae_pipe_reg #(.WIDTH(P_W), .REGISTERED(MULT_HAS_REG)) u_m_reg (
      .CLK(CLK), .ARST(ARST), .EN(bus.P_EN), .SRST_N(bus.P_SRST_N),
      .D(m), .Q(m_q)
   );

   // Feedback path only exists when P is registered, so no combinational loop is built.
   if (USE_FEEDBACK) begin : g_fdbk
      assign x = bus.CDIN_FDBK_SEL ? p_q : c_q;
   end else begin : g_no_fdbk
      logic unused_sel;
      assign unused_sel = bus.CDIN_FDBK_SEL;
      assign x = c_q;
   end

   if (POST_ADDER_STATIC) begin : g_add
      assign s = m_q + x;
   end else begin : g_no_add
      logic unused_x;
      assign unused_x = ^x;
      assign s = m_q;
   end

   mae_pipe_reg #(.WIDTH(P_W), .REGISTERED(BYPASS_P)) u_p_reg (
      .CLK(CLK), .ARST(ARST), .EN(bus.P_EN), .SRST_N(bus.P_SRST_N),
      .D(s), .Q(p_q)
   );

   assign bus.P = p_q;

endmodule

// File: tb/tb_mae_dsp_core.sv
// Self-checking bench for mae_dsp_core across combinational, pipelined,
// post-adder and accumulate configurations.
module tb_mae_dsp_core;
   import mae_pkg::*;

   logic CLK = 1'b0;
   logic ARST;
   always #5 CLK = ~CLK;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   mae_dsp_core_if if0 ();
   mae_dsp_core_if if1 ();
   mae_dsp_core_if if2 ();
   mae_dsp_core_if if3 ();

   // Fully combinational, product only.
   mae_dsp_core #(.BYPASS_A(1'b0), .BYPASS_B(1'b0), .BYPASS_C(1'b0), .BYPASS_P(1'b0),
                  .MULT_HAS_REG(1'b0), .POST_ADDER_STATIC(1'b0), .USE_FEEDBACK(1'b0))
      dut0 (.CLK(CLK), .ARST(ARST), .bus(if0));
   // Full product pipeline, latency 3.
   mae_dsp_core #(.BYPASS_A(1'b1), .BYPASS_B(1'b1), .BYPASS_C(1'b0), .BYPASS_P(1'b1),
                  .MULT_HAS_REG(1'b1), .POST_ADDER_STATIC(1'b0), .USE_FEEDBACK(1'b0))
      dut1 (.CLK(CLK), .ARST(ARST), .bus(if1));
   // Post-adder with registered C and P.
   mae_dsp_core #(.BYPASS_A(1'b0), .BYPASS_B(1'b0), .BYPASS_C(1'b1), .BYPASS_P(1'b1),
                  .MULT_HAS_REG(1'b0), .POST_ADDER_STATIC(1'b1), .USE_FEEDBACK(1'b0))
      dut2 (.CLK(CLK), .ARST(ARST), .bus(if2));
   // Accumulator.
   mae_dsp_core #(.BYPASS_A(1'b1), .BYPASS_B(1'b1), .BYPASS_C(1'b0), .BYPASS_P(1'b1),
                  .MULT_HAS_REG(1'b0), .POST_ADDER_STATIC(1'b1), .USE_FEEDBACK(1'b1))
      dut3 (.CLK(CLK), .ARST(ARST), .bus(if3));

   `define IDLE(i) begin i.A = '0; i.B = '0; i.C = '0; i.A_EN = 1'b1; i.B_EN = 1'b1; \
      i.C_EN = 1'b1; i.A_SRST_N = 1'b1; i.B_SRST_N = 1'b1; i.C_SRST_N = 1'b1; \
      i.P_EN = 1'b1; i.P_SRST_N = 1'b1; i.CDIN_FDBK_SEL = 1'b0; end

   function automatic logic [P_W-1:0] prod(input logic signed [A_W-1:0] a,
                                           input logic signed [B_W-1:0] b);
      longint r;
      r = longint'(a) * longint'(b);
      return P_W'(r);
   endfunction

   task automatic chk(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic signed [A_W-1:0] a;
      logic signed [B_W-1:0] b;
      logic [P_W-1:0]        p;
   } mul_vec_t;

   typedef struct {
      logic           en;
      logic           srst_n;
      logic [P_W-1:0] p;
   } acc_vec_t;

   mul_vec_t mvec[6];
   acc_vec_t avec[10];

   logic signed [A_W-1:0] qa[$];
   logic signed [B_W-1:0] qb[$];
   logic [C_W-1:0]        qc[$];
   logic signed [A_W-1:0] ra;
   logic signed [B_W-1:0] rb;
   logic [C_W-1:0]        rc;
   logic [P_W-1:0]        acc;
   logic [P_W-1:0]        held;
   logic                  ren;
   logic                  rsrst;

   initial begin
      mvec[0] = '{18'sd3,      -18'sd5,    40'hFF_FFFF_FFF1};
      mvec[1] = '{18'sd0,      18'sd12345, 40'h00_0000_0000};
      mvec[2] = '{18'sd131071, 18'sd131071, 40'h03_FFFC_0001};
      mvec[3] = '{18'h20000,   18'h20000,  40'h04_0000_0000};
      mvec[4] = '{18'h20000,   18'sd131071, 40'hFC_0002_0000};
      mvec[5] = '{18'sd1,      -18'sd1,    40'hFF_FFFF_FFFF};

      // Accumulate A=3,B=4: first edge only fills the A/B registers.
      avec[0] = '{1'b1, 1'b1, 40'd0};
      avec[1] = '{1'b1, 1'b1, 40'd12};
      avec[2] = '{1'b1, 1'b1, 40'd24};
      avec[3] = '{1'b1, 1'b1, 40'd36};
      avec[4] = '{1'b0, 1'b1, 40'd36};
      avec[5] = '{1'b0, 1'b1, 40'd36};
      avec[6] = '{1'b1, 1'b0, 40'd0};
      avec[7] = '{1'b1, 1'b1, 40'd12};
      avec[8] = '{1'b1, 1'b1, 40'd24};
      avec[9] = '{1'b0, 1'b0, 40'd0};

      ARST = 1'b1;
      `IDLE(if0) `IDLE(if1) `IDLE(if2) `IDLE(if3)
      if1.A = 18'sd5; if1.B = 18'sd7;
      if2.A = 18'sd3; if2.B = 18'sd3; if2.C = 40'h123;
      @(negedge CLK);
      chk("reset_p1", if1.P, 40'd0);
      chk("reset_p2", if2.P, 40'd0);
      chk("reset_p3", if3.P, 40'd0);
      @(posedge CLK); #1;
      ARST = 1'b0;
      `IDLE(if0) `IDLE(if1) `IDLE(if2) `IDLE(if3)
      repeat (4) @(posedge CLK);
      #1;

      // Combinational core: table then random, with enables/clears toggling (ignored).
      for (int i = 0; i < 6; i++) begin
         if0.A = mvec[i].a; if0.B = mvec[i].b;
         if0.C = {$urandom, $urandom};
         {if0.A_EN, if0.B_EN, if0.C_EN, if0.P_EN} = 4'($urandom);
         {if0.A_SRST_N, if0.B_SRST_N, if0.C_SRST_N, if0.P_SRST_N} = 4'($urandom);
         @(negedge CLK);
         chk($sformatf("comb_vec%0d", i), if0.P, mvec[i].p);
         @(posedge CLK); #1;
      end
      for (int i = 0; i < 40; i++) begin
         ra = A_W'($urandom); rb = B_W'($urandom);
         if0.A = ra; if0.B = rb;
         if0.C = {$urandom, $urandom};
         {if0.A_EN, if0.B_EN, if0.C_EN, if0.P_EN} = 4'($urandom);
         {if0.A_SRST_N, if0.B_SRST_N, if0.C_SRST_N, if0.P_SRST_N} = 4'($urandom);
         @(negedge CLK);
         chk("comb_rand", if0.P, prod(ra, rb));
         @(posedge CLK); #1;
      end

      // Pipelined product: single pulse appears exactly 3 edges later.
      if1.A = 18'sd100; if1.B = 18'sd200;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         chk($sformatf("pipe_pulse_k%0d", k), if1.P, (k == 3) ? 40'd20000 : 40'd0);
         @(posedge CLK); #1;
         if1.A = '0; if1.B = '0;
      end
      qa.delete(); qb.delete();
      for (int k = 0; k < 3; k++) begin qa.push_back('0); qb.push_back('0); end
      for (int i = 0; i < 40; i++) begin
         ra = A_W'($urandom); rb = B_W'($urandom);
         if1.A = ra; if1.B = rb;
         qa.push_back(ra); qb.push_back(rb);
         @(negedge CLK);
         chk("pipe_rand", if1.P, prod(qa[qa.size()-4], qb[qb.size()-4]));
         @(posedge CLK); #1;
      end
      if1.A = '0; if1.B = '0;

      // Post-adder: product lands after 1 edge, C after 2.
      qa.delete(); qb.delete(); qc.delete();
      qa.push_back('0); qb.push_back('0); qc.push_back('0); qc.push_back('0);
      for (int i = 0; i < 40; i++) begin
         ra = A_W'($urandom); rb = B_W'($urandom); rc = {$urandom, $urandom};
         if2.A = ra; if2.B = rb; if2.C = rc;
         qa.push_back(ra); qb.push_back(rb); qc.push_back(rc);
         @(negedge CLK);
         chk("add_rand", if2.P,
             prod(qa[qa.size()-2], qb[qb.size()-2]) + qc[qc.size()-3]);
         @(posedge CLK); #1;
      end
      if2.A = 18'h20000; if2.B = 18'h20000; if2.C = 40'h7F_FFFF_FFFF;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("add_wrap", if2.P, 40'h83_FFFF_FFFF);
      // Clear C while its enable is low, then keep it held at zero.
      if2.C_SRST_N = 1'b0; if2.C_EN = 1'b0;
      @(posedge CLK); #1;
      if2.C_SRST_N = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("add_c_clear_hold", if2.P, 40'h04_0000_0000);
      `IDLE(if2)

      // Accumulator hand sequence.
      if3.A = 18'sd3; if3.B = 18'sd4; if3.CDIN_FDBK_SEL = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if3.P_EN = avec[i].en; if3.P_SRST_N = avec[i].srst_n;
         @(posedge CLK);
         @(negedge CLK);
         chk($sformatf("acc_seq%0d", i), if3.P, avec[i].p);
      end
      acc = '0; held = 40'd12;
      for (int i = 0; i < 40; i++) begin
         ra = A_W'($urandom); rb = B_W'($urandom);
         ren = ($urandom_range(0, 3) != 0);
         rsrst = ($urandom_range(0, 9) != 0);
         if3.A = ra; if3.B = rb; if3.P_EN = ren; if3.P_SRST_N = rsrst;
         @(posedge CLK);
         if (!rsrst)  acc = '0;
         else if (ren) acc = acc + held;
         held = prod(ra, rb);
         @(negedge CLK);
         chk("acc_rand", if3.P, acc);
      end
      if3.P_EN = 1'b1; if3.P_SRST_N = 1'b1;

      // Asynchronous reset between edges on a loaded pipeline.
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         if1.A = A_W'($urandom_range(1, 1000)); if1.B = B_W'($urandom_range(1, 1000));
      end
      @(negedge CLK);
      chk("pre_arst_nonzero", 40'(if1.P != 0), 40'd1);
      #2 ARST = 1'b1;
      #1;
      chk("arst_async_p1", if1.P, 40'd0);
      chk("arst_async_p3", if3.P, 40'd0);
      #1 ARST = 1'b0;
      if1.A = 18'sd2; if1.B = 18'sd2;
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLK);
         chk($sformatf("arst_reload_k%0d", k), if1.P, (k == 3) ? 40'd4 : 40'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
